// File: rtl/fir_addr_sequencer_if.sv
// ---------------------------------------------------------------------------
// fir_addr_sequencer_if
// Bundle between the FIR address sequencer and its neighbours: the
// sample-input handshake, the 8-bit address register, the coefficient ROM
// and the MAC unit.
//
// Signals (direction seen from the sequencer, i.e. the master modport):
//   start     in   new-sample request
//   ld        out  load strobe to the address register
//   addr_out  out  sample-buffer address presented with ld
//   we        out  sample-buffer write enable
//   coef_addr out  coefficient ROM address
//   acc_clr   out  accumulator clear
//   mac_en    out  MAC enable, aligned with the address-register output
//   busy      out  sequencer not idle
//   done      out  one-cycle result-valid pulse
//   overrun   out  sticky start-while-busy flag   (FIR_SEQ_OVERRUN_EN only)
//   ovr_clr   in   clears overrun                 (FIR_SEQ_OVERRUN_EN only)
// ---------------------------------------------------------------------------
interface fir_addr_sequencer_if #(
  parameter int AW = 8
);
  logic          start;
  logic          ld;
  logic [AW-1:0] addr_out;
  logic          we;
  logic [AW-1:0] coef_addr;
  logic          acc_clr;
  logic          mac_en;
  logic          busy;
  logic          done;
`ifdef FIR_SEQ_OVERRUN_EN
  logic          overrun;
  logic          ovr_clr;

  modport master (
    input  start, ovr_clr,
    output ld, addr_out, we, coef_addr, acc_clr, mac_en, busy, done, overrun
  );
  modport slave (
    output start, ovr_clr,
    input  ld, addr_out, we, coef_addr, acc_clr, mac_en, busy, done, overrun
  );
`else
  modport master (
    input  start,
    output ld, addr_out, we, coef_addr, acc_clr, mac_en, busy, done
  );
  modport slave (
    output start,
    input  ld, addr_out, we, coef_addr, acc_clr, mac_en, busy, done
  );
`endif
endinterface

// File: rtl/fir_addr_sequencer.sv
// ---------------------------------------------------------------------------
// fir_addr_sequencer
// Initiator side of the FIR address-register load interface. For every
// accepted start it writes the new sample into a circular buffer (WRITE),
// walks TAPS sample/coefficient address pairs newest-to-oldest (MAC), lets
// the last tap flow through the address register (DRAIN) and pulses done
// (DONE). Outputs are Moore-decoded from state/counters; mac_en is a
// dedicated flop so it lines up with the address register's output.
//
// Parameters: TAPS (2..128), AW (address width), SBASE (sample buffer base),
//             CBASE (coefficient table base).
// Ports:      clk, rst (async, active-high), bus (fir_addr_sequencer_if
//             master modport: start in; ld, addr_out, we, coef_addr,
//             acc_clr, mac_en, busy, done out).
// Option:     define FIR_SEQ_OVERRUN_EN to add the sticky overrun flag and
//             its ovr_clr input; without it a start while busy is dropped.
// ---------------------------------------------------------------------------
module fir_addr_sequencer #(
  parameter int            TAPS  = 8,
  parameter int            AW    = 8,
  parameter logic [AW-1:0] SBASE = 8'h00,
  parameter logic [AW-1:0] CBASE = 8'h80
) (
  input  logic                 clk,
  input  logic                 rst,
  fir_addr_sequencer_if.master bus
);

  localparam int            KW    = $clog2(TAPS);
  localparam logic [KW-1:0] KLAST = KW'(TAPS - 1);

  typedef enum logic [2:0] {IDLE, WRITE, MAC, DRAIN, DONE} state_t;

  state_t        state, state_nxt;
  logic [KW-1:0] k, k_nxt;
  logic [KW-1:0] wr_ptr, wr_ptr_nxt;
  logic          mac_en_q;
  logic [AW-1:0] idx;

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      k        <= '0;
      wr_ptr   <= '0;
      mac_en_q <= 1'b0;
    end else begin
      state    <= state_nxt;
      k        <= k_nxt;
      wr_ptr   <= wr_ptr_nxt;
      mac_en_q <= (state == MAC);
    end
  end

  // Circular-buffer index of the sample k steps older than the newest one.
  // TAPS need not be a power of two, so wrap by adding TAPS, not by masking.
  always_comb begin
    if (wr_ptr >= k) idx = AW'(wr_ptr) - AW'(k);
    else             idx = AW'(wr_ptr) + AW'(TAPS) - AW'(k);
  end

  // NOTE: every signal driven here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_nxt     = state;
    k_nxt         = k;
    wr_ptr_nxt    = wr_ptr;
    bus.ld        = 1'b0;
    bus.we        = 1'b0;
    bus.acc_clr   = 1'b0;
    bus.done      = 1'b0;
    bus.addr_out  = SBASE;
    bus.coef_addr = CBASE;
    bus.busy      = (state != IDLE);
    case (state)
      IDLE: begin
        if (bus.start) state_nxt = WRITE;
      end
      WRITE: begin
        bus.ld       = 1'b1;
        bus.we       = 1'b1;
        bus.acc_clr  = 1'b1;
        bus.addr_out = SBASE + AW'(wr_ptr);
        k_nxt        = '0;
        state_nxt    = MAC;
      end
      MAC: begin
        bus.ld        = 1'b1;
        bus.addr_out  = SBASE + idx;
        bus.coef_addr = CBASE + AW'(k);
        if (k == KLAST) state_nxt = DRAIN;
        else            k_nxt     = k + 1'b1;
      end
      DRAIN: begin
        state_nxt = DONE;
      end
      DONE: begin
        bus.done   = 1'b1;
        wr_ptr_nxt = (wr_ptr == KLAST) ? '0 : wr_ptr + 1'b1;
        state_nxt  = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign bus.mac_en = mac_en_q;

`ifdef FIR_SEQ_OVERRUN_EN
  // Sticky start-while-busy flag; a new overrun on the clearing edge wins.
  logic overrun_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                             overrun_q <= 1'b0;
    else if (bus.start && state != IDLE) overrun_q <= 1'b1;
    else if (bus.ovr_clr)                overrun_q <= 1'b0;
  end

  assign bus.overrun = overrun_q;
`else
  // Without the overrun option a start while busy is simply dropped.
`endif

endmodule

// File: tb/tb_fir_addr_sequencer.sv
// ---------------------------------------------------------------------------
// tb_fir_addr_sequencer
// Scoreboard bench for fir_addr_sequencer. Two instances: TAPS=8 and TAPS=5.
// Stimulus pushes the expected WRITE / MAC / DONE events into a per-instance
// queue; a negedge monitor pops and compares whenever ld or done is seen and
// tracks mac_en against the previous cycle's MAC-phase ld.
// ---------------------------------------------------------------------------
module tb_fir_addr_sequencer;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fir_addr_sequencer_if #(.AW(8)) b8 ();
  fir_addr_sequencer_if #(.AW(8)) b5 ();

  fir_addr_sequencer #(.TAPS(8), .AW(8), .SBASE(8'h00), .CBASE(8'h80)) dut8 (
    .clk(clk), .rst(rst), .bus(b8)
  );
  fir_addr_sequencer #(.TAPS(5), .AW(8), .SBASE(8'h00), .CBASE(8'h80)) dut5 (
    .clk(clk), .rst(rst), .bus(b5)
  );

  typedef enum logic [1:0] {E_WRITE, E_MAC, E_DONE} ekind_t;
  typedef struct packed {
    ekind_t     kind;
    logic [7:0] addr;
    logic [7:0] coef;
  } exp_t;

  exp_t q8[$];
  exp_t q5[$];
  int   done_t8[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  logic [7:0] seq [2][8];
  int   mi [2];
  logic prev_mac [2];

  // Hand-computed MAC address sequences.
  logic [7:0] tab_wp0 [8] = '{8'h00, 8'h07, 8'h06, 8'h05, 8'h04, 8'h03, 8'h02, 8'h01};
  logic [7:0] tab_wp3 [8] = '{8'h03, 8'h02, 8'h01, 8'h00, 8'h07, 8'h06, 8'h05, 8'h04};
  logic [7:0] tab5_wp1 [5] = '{8'h01, 8'h00, 8'h04, 8'h03, 8'h02};

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic mon(input int s, input logic ld, we, acc, dn, bsy, men,
                     input logic [7:0] addr, coef);
    exp_t  e;
    string p;
    p = (s != 0) ? "t5" : "t8";
    if (rst) begin
      prev_mac[s] = 1'b0;
      check({p, "_mac_en_in_rst"}, men, 0);
      return;
    end
    check({p, "_mac_en"}, men, prev_mac[s]);
    prev_mac[s] = ld & ~we;
    if (ld | dn) begin
      if ((s == 0 && q8.size() == 0) || (s != 0 && q5.size() == 0)) begin
        checks++;
        errors++;
        $display("FAIL %s_unexpected actual ld=%0b done=%0b addr=%0h required no activity",
                 p, ld, dn, addr);
      end else begin
        e = (s != 0) ? q5.pop_front() : q8.pop_front();
        check({p, "_busy"}, bsy, 1);
        case (e.kind)
          E_WRITE: begin
            check({p, "_write_strobes"}, {ld, we, acc, dn}, 4'b1110);
            check({p, "_write_addr"}, addr, e.addr);
            mi[s] = 0;
          end
          E_MAC: begin
            check({p, "_mac_strobes"}, {ld, we, acc, dn}, 4'b1000);
            check({p, "_mac_addr"}, addr, e.addr);
            check({p, "_coef_addr"}, coef, e.coef);
            if (mi[s] < 8) seq[s][mi[s]] = addr;
            mi[s]++;
          end
          default: begin
            check({p, "_done_strobes"}, {ld, we, acc, dn}, 4'b0001);
            if (s == 0) done_t8.push_back(cyc);
          end
        endcase
      end
    end
  endtask

  always @(negedge clk) begin
    mon(0, b8.ld, b8.we, b8.acc_clr, b8.done, b8.busy, b8.mac_en, b8.addr_out, b8.coef_addr);
    mon(1, b5.ld, b5.we, b5.acc_clr, b5.done, b5.busy, b5.mac_en, b5.addr_out, b5.coef_addr);
  end

  function automatic logic done_of(input int s);
    return (s != 0) ? b5.done : b8.done;
  endfunction

  task automatic set_start(input int s, input logic v);
    if (s != 0) b5.start = v;
    else        b8.start = v;
  endtask

  task automatic push(input int s, input exp_t e);
    if (s != 0) q5.push_back(e);
    else        q8.push_back(e);
  endtask

  // Expected events for one sample at write pointer wp; nk MAC taps.
  task automatic push_sample(input int s, input int wp, input int nk);
    int   taps;
    int   idx;
    exp_t e;
    taps   = (s != 0) ? 5 : 8;
    e.kind = E_WRITE; e.addr = 8'(wp); e.coef = 8'h80;
    push(s, e);
    for (int k = 0; k < nk; k++) begin
      idx    = (wp >= k) ? wp - k : wp - k + taps;
      e.kind = E_MAC; e.addr = 8'(idx); e.coef = 8'(128 + k);
      push(s, e);
    end
    if (nk == taps) begin
      e.kind = E_DONE; e.addr = 8'h00; e.coef = 8'h80;
      push(s, e);
    end
  endtask

  task automatic run_sample(input int s, input int wp);
    int n;
    int taps;
    taps = (s != 0) ? 5 : 8;
    push_sample(s, wp, taps);
    @(negedge clk); set_start(s, 1'b1);
    @(negedge clk); set_start(s, 1'b0);
    n = 1;
    while (!done_of(s) && n < 40) begin
      @(negedge clk);
      n++;
    end
    check((s != 0) ? "t5_done_latency" : "t8_done_latency", n, taps + 3);
    @(negedge clk);
  endtask

  task automatic wait_drain(input int s, input int budget);
    int n;
    n = 0;
    while (((s == 0) ? (q8.size() != 0 || b8.busy) : (q5.size() != 0 || b5.busy)) && n < budget) begin
      @(negedge clk); #1;
      n++;
    end
    check((s != 0) ? "t5_drain_timeout" : "t8_drain_timeout", (n < budget), 1);
  endtask

  task automatic pulse_rst();
    @(negedge clk); rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst = 1'b1;
    b8.start = 1'b0;
    b5.start = 1'b0;
`ifdef FIR_SEQ_OVERRUN_EN
    b8.ovr_clr = 1'b0;
    b5.ovr_clr = 1'b0;
`endif
    repeat (3) @(negedge clk);
    #1;
    check("rst_ld", b8.ld, 0);
    check("rst_we", b8.we, 0);
    check("rst_acc_clr", b8.acc_clr, 0);
    check("rst_busy", b8.busy, 0);
    check("rst_done", b8.done, 0);
    check("rst_mac_en", b8.mac_en, 0);
    check("rst_addr_out", b8.addr_out, 8'h00);
    check("rst_coef_addr", b8.coef_addr, 8'h80);
`ifdef FIR_SEQ_OVERRUN_EN
    check("rst_overrun", b8.overrun, 0);
`endif
    @(negedge clk); rst = 1'b0;
    @(negedge clk); #1;
    check("idle_busy", b8.busy, 0);

    // Reset in the middle of the MAC phase of the first sample.
    push_sample(0, 0, 3);
    @(negedge clk); b8.start = 1'b1;
    @(negedge clk); b8.start = 1'b0; #1;
    n = 0;
    while (q8.size() != 0 && n < 20) begin
      @(negedge clk); #1;
      n++;
    end
    check("midmac_reached", q8.size(), 0);
    rst = 1'b1;
    #1;
    check("midmac_rst_ld", b8.ld, 0);
    check("midmac_rst_busy", b8.busy, 0);
    check("midmac_rst_done", b8.done, 0);
    check("midmac_rst_addr", b8.addr_out, 8'h00);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Nine samples: pointer walks 0..7 and wraps back to 0.
    for (int i = 0; i < 9; i++) begin
      run_sample(0, i % 8);
      if (i == 0 || i == 8)
        for (int k = 0; k < 8; k++) check($sformatf("t8_seq_s%0d_k%0d", i + 1, k), seq[0][k], tab_wp0[k]);
      if (i == 3)
        for (int k = 0; k < 8; k++) check($sformatf("t8_seq_s4_k%0d", k), seq[0][k], tab_wp3[k]);
    end

    // Start while busy (at MAC k=3) is ignored.
    push_sample(0, 1, 8);
    @(negedge clk); b8.start = 1'b1;
    @(negedge clk); b8.start = 1'b0;
    repeat (4) @(negedge clk);
    b8.start = 1'b1;
    @(negedge clk); b8.start = 1'b0;
`ifdef FIR_SEQ_OVERRUN_EN
    #1;
    check("overrun_set", b8.overrun, 1);
`endif
    wait_drain(0, 40);
    repeat (15) @(negedge clk);
    #1;
    check("busy_start_no_extra", q8.size(), 0);
    check("busy_start_idle", b8.busy, 0);
`ifdef FIR_SEQ_OVERRUN_EN
    check("overrun_sticky", b8.overrun, 1);
    @(negedge clk); b8.ovr_clr = 1'b1;
    @(negedge clk); b8.ovr_clr = 1'b0; #1;
    check("overrun_cleared", b8.overrun, 0);
    push_sample(0, 2, 8);
    @(negedge clk); b8.start = 1'b1;
    @(negedge clk); b8.start = 1'b0;
    repeat (3) @(negedge clk);
    b8.start = 1'b1; b8.ovr_clr = 1'b1;
    @(negedge clk); b8.start = 1'b0; b8.ovr_clr = 1'b0; #1;
    check("overrun_set_wins", b8.overrun, 1);
    wait_drain(0, 40);
    @(negedge clk); b8.ovr_clr = 1'b1;
    @(negedge clk); b8.ovr_clr = 1'b0; #1;
    check("overrun_cleared2", b8.overrun, 0);
`endif

    // Held start: re-triggers one cycle after done, pointer 0,1,2.
    pulse_rst();
    done_t8.delete();
    push_sample(0, 0, 8);
    push_sample(0, 1, 8);
    push_sample(0, 2, 8);
    @(negedge clk); b8.start = 1'b1;
    repeat (30) @(negedge clk);
    b8.start = 1'b0;
    wait_drain(0, 60);
    check("held_done_count", done_t8.size(), 3);
    if (done_t8.size() == 3) begin
      check("held_spacing_1", done_t8[1] - done_t8[0], 12);
      check("held_spacing_2", done_t8[2] - done_t8[1], 12);
    end

    // TAPS=5: non-power-of-two wrap; sixth sample writes address 0 again.
    for (int i = 0; i < 6; i++) begin
      run_sample(1, i % 5);
      if (i == 1)
        for (int k = 0; k < 5; k++) check($sformatf("t5_seq_wp1_k%0d", k), seq[1][k], tab5_wp1[k]);
    end

    repeat (3) @(negedge clk);
    check("t8_queue_empty", q8.size(), 0);
    check("t5_queue_empty", q5.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
